gemm_sequencer: RTL and testbench

//   Sequences one GEMM tile on systolic_array_top: accepts a tile command (top/left/down SRAM

---
 rtl/gemm_sequencer_pkg.sv | 17 +
 rtl/gemm_sequencer.sv | 148 ++++++++++++++
 tb/tb_gemm_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gemm_sequencer_pkg.sv
// Shared GEMM sequencing constants: array control state codes and the
// instruction opcodes decoded upstream by inst_reader.
package gemm_sequencer_pkg;

  localparam int CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_WARMUP = 4'd1,
    ST_STEADY = 4'd2,
    ST_DRAIN  = 4'd3
  } ctrl_state_e;

  localparam logic [3:0] OPCODE_GEMM     = 4'b0100;
  localparam logic [3:0] OPCODE_DRAINSYS = 4'b0101;

endpackage

// File: rtl/gemm_sequencer.sv
// Sequences one GEMM tile: checks and latches the SRAM address windows, then steps
// the array control state IDLE->WARMUP->STEADY->DRAIN->IDLE with exact phase lengths.
module gemm_sequencer
  import gemm_sequencer_pkg::*;
#(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int WARMUP_CYCLES        = 1,
  parameter int DRAIN_CYCLES         = NUM_ROW + NUM_COL
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_top_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_top_end,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_left_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_left_end,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_down_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_down_end,
  input  logic                            i_abort,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_cmd_err
);

  localparam int AW    = LOG2_SRAM_BANK_DEPTH;
  localparam int CNT_W = ((AW + 1) > $clog2(DRAIN_CYCLES + 1)) ? (AW + 1) : $clog2(DRAIN_CYCLES + 1);

  ctrl_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_k;
  logic             r_done, r_err, w_done_nxt, w_err_nxt, w_accept;
  logic [AW-1:0]    r_top_s, r_top_e, r_left_s, r_left_e, r_down_s, r_down_e;
  logic [AW-1:0]    w_top_span, w_left_span;
  logic [AW:0]      w_k;
  logic             w_cmd_bad;

  // Spans are only meaningful when end>=start; the ordering checks guard the subtraction.
  assign w_top_span  = i_cmd_top_end - i_cmd_top_start;
  assign w_left_span = i_cmd_left_end - i_cmd_left_start;
  assign w_k         = {1'b0, w_top_span} + (AW + 1)'(1);
  assign w_cmd_bad   = (i_cmd_top_end < i_cmd_top_start) ||
                       (i_cmd_left_end < i_cmd_left_start) ||
                       (w_top_span != w_left_span);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (w_cmd_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WARMUP;
            w_cnt_nxt   = CNT_W'(WARMUP_CYCLES);
          end
        end
      end
      ST_WARMUP: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_STEADY;
          w_cnt_nxt   = r_k;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_STEADY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_W'(DRAIN_CYCLES);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides any phase transition, including the final DRAIN cycle.
    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_top_s  <= '0;
      r_top_e  <= '0;
      r_left_s <= '0;
      r_left_e <= '0;
      r_down_s <= '0;
      r_down_e <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_k      <= CNT_W'(w_k);
        r_top_s  <= i_cmd_top_start;
        r_top_e  <= i_cmd_top_end;
        r_left_s <= i_cmd_left_start;
        r_left_e <= i_cmd_left_end;
        r_down_s <= i_cmd_down_start;
        r_down_e <= i_cmd_down_end;
      end
    end
  end

  assign o_cmd_ready               = (r_state == ST_IDLE);
  assign o_busy                    = (r_state != ST_IDLE);
  assign o_ctrl_state              = CTRL_WIDTH'(r_state);
  assign o_done                    = r_done;
  assign o_cmd_err                 = r_err;
  assign o_top_sram_rd_start_addr  = r_top_s;
  assign o_top_sram_rd_end_addr    = r_top_e;
  assign o_left_sram_rd_start_addr = r_left_s;
  assign o_left_sram_rd_end_addr   = r_left_e;
  assign o_down_sram_rd_start_addr = r_down_s;
  assign o_down_sram_rd_end_addr   = r_down_e;

endmodule

// File: tb/tb_gemm_sequencer.sv
// Directed bench for gemm_sequencer: tile timing, command rejection, abort, held valid, reset.
module tb_gemm_sequencer;

  localparam int AW = 5;
  localparam int W  = 1;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cmd_valid, i_abort;
  logic [AW-1:0] i_ts, i_te, i_ls, i_le, i_ds, i_de;
  logic          o_cmd_ready, o_busy, o_done, o_cmd_err;
  logic [3:0]    o_ctrl_state;
  logic [AW-1:0] o_ts, o_te, o_ls, o_le, o_ds, o_de;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gemm_sequencer dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_cmd_valid               (i_cmd_valid),
    .o_cmd_ready               (o_cmd_ready),
    .i_cmd_top_start           (i_ts),
    .i_cmd_top_end             (i_te),
    .i_cmd_left_start          (i_ls),
    .i_cmd_left_end            (i_le),
    .i_cmd_down_start          (i_ds),
    .i_cmd_down_end            (i_de),
    .i_abort                   (i_abort),
    .o_ctrl_state              (o_ctrl_state),
    .o_top_sram_rd_start_addr  (o_ts),
    .o_top_sram_rd_end_addr    (o_te),
    .o_left_sram_rd_start_addr (o_ls),
    .o_left_sram_rd_end_addr   (o_le),
    .o_down_sram_rd_start_addr (o_ds),
    .o_down_sram_rd_end_addr   (o_de),
    .o_busy                    (o_busy),
    .o_done                    (o_done),
    .o_cmd_err                 (o_cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [AW-1:0] ts, te, ls, le, ds, de);
    i_cmd_valid = v;
    i_ts = ts; i_te = te; i_ls = ls; i_le = le; i_ds = ds; i_de = de;
  endtask

  function automatic logic [31:0] addrs();
    return {2'b0, o_ts, o_te, o_ls, o_le, o_ds, o_de};
  endfunction

  function automatic logic [31:0] pack(input logic [AW-1:0] ts, te, ls, le, ds, de);
    return {2'b0, ts, te, ls, le, ds, de};
  endfunction

  // Entered in the first WARMUP cycle; returns in the o_done cycle.
  task automatic run_tile(input string tag, input int k, input logic [31:0] exp_addr);
    int total;
    logic [3:0] exp_st;
    total = W + k + D;
    for (int i = 0; i <= total; i++) begin
      exp_st = (i < W) ? 4'd1 : (i < W + k) ? 4'd2 : (i < total) ? 4'd3 : 4'd0;
      chk($sformatf("%s state c%0d", tag, i), o_ctrl_state, exp_st);
      chk($sformatf("%s done c%0d", tag, i), o_done, (i == total));
      chk($sformatf("%s busy c%0d", tag, i), o_busy, (exp_st != 4'd0));
      chk($sformatf("%s ready c%0d", tag, i), o_cmd_ready, (exp_st == 4'd0));
      if (i == 0 || i == W + 1 || i == total)
        chk($sformatf("%s addr c%0d", tag, i), addrs(), exp_addr);
      if (i < total) tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_abort = 1'b0;
    set_cmd(1'b0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst state", o_ctrl_state, 0);
    chk("rst addr", addrs(), 0);
    chk("rst flags", {o_busy, o_done, o_cmd_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst ready", o_cmd_ready, 1);
    chk("post-rst state", o_ctrl_state, 0);
    chk("post-rst flags", {o_busy, o_done, o_cmd_err}, 0);

    // Basic tile, K=4
    set_cmd(1'b1, 0, 3, 8, 11, 16, 19);
    tick();
    i_cmd_valid = 1'b0;
    run_tile("k4", 4, pack(0, 3, 8, 11, 16, 19));
    tick();
    chk("k4 done clear", o_done, 0);

    // Full-depth window, K=32
    set_cmd(1'b1, 0, 31, 0, 31, 0, 0);
    tick();
    i_cmd_valid = 1'b0;
    run_tile("k32", 32, pack(0, 31, 0, 31, 0, 0));
    tick();

    // Rejections: inverted top window, then mismatched spans
    set_cmd(1'b1, 5, 2, 8, 11, 16, 19);
    tick();
    chk("err1 pulse", o_cmd_err, 1);
    chk("err1 state", o_ctrl_state, 0);
    chk("err1 addr held", addrs(), pack(0, 31, 0, 31, 0, 0));
    i_cmd_valid = 1'b0;
    tick();
    chk("err1 clear", o_cmd_err, 0);
    set_cmd(1'b1, 0, 3, 0, 4, 16, 19);
    tick();
    chk("err2 pulse", o_cmd_err, 1);
    chk("err2 busy", o_busy, 0);
    i_cmd_valid = 1'b0;
    tick();
    chk("err2 clear", o_cmd_err, 0);
    chk("err2 state", o_ctrl_state, 0);

    // Abort on the 2nd STEADY cycle
    set_cmd(1'b1, 0, 3, 8, 11, 16, 19);
    tick();
    i_cmd_valid = 1'b0;
    chk("ab warmup", o_ctrl_state, 1);
    tick();
    chk("ab steady1", o_ctrl_state, 2);
    tick();
    chk("ab steady2", o_ctrl_state, 2);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("ab state", o_ctrl_state, 0);
    chk("ab no done", o_done, 0);
    chk("ab busy", o_busy, 0);
    chk("ab addr held", addrs(), pack(0, 3, 8, 11, 16, 19));

    // New command right after abort; a second command is held valid while busy
    set_cmd(1'b1, 1, 2, 3, 4, 5, 6);
    tick();
    set_cmd(1'b1, 2, 4, 10, 12, 0, 1);
    run_tile("held", 2, pack(1, 2, 3, 4, 5, 6));
    i_abort = 1'b1;
    tick();
    i_abort     = 1'b0;
    i_cmd_valid = 1'b0;
    run_tile("B", 3, pack(2, 4, 10, 12, 0, 1));
    tick();

    // Async reset mid-tile
    set_cmd(1'b1, 0, 3, 8, 11, 16, 19);
    tick();
    i_cmd_valid = 1'b0;
    tick();
    tick();
    chk("ar pre state", o_ctrl_state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar state", o_ctrl_state, 0);
    chk("ar addr", addrs(), 0);
    chk("ar flags", {o_busy, o_done, o_cmd_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar ready", o_cmd_ready, 1);
    chk("ar done", o_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
